stream_demux2: RTL and testbench

- Registered 1-to-2 stream demultiplexer. It is the fan-out counterpart of the team's 2:1 data-select mux.
- One valid/ready input stream carries a select bit with each beat. The block steers each beat to output port A (Sel=0) or port B (Sel=1).
- Each output has a one-entry holding register, so each output applies backpressure independently.
- Per-output beat counters support bring-up and debug. The block sits between a shared producer and two independent consumers.

---
 rtl/stream_demux2.sv | 112 +++++++++++
 tb/tb_stream_demux2.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/stream_demux2.sv
// stream_demux2: registered 1-to-2 valid/ready demultiplexer.
// Each beat is steered to port A (In_Sel=0) or port B (In_Sel=1).
// Each output owns a one-entry holding register and a wrapping handshake counter.
module stream_demux2 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Sel,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] A_Data,
  output logic             A_Valid,
  input  logic             A_Ready,
  output logic [WIDTH-1:0] B_Data,
  output logic             B_Valid,
  input  logic             B_Ready,
  input  logic             Clr,
  output logic [CNT_W-1:0] A_Count,
  output logic [CNT_W-1:0] B_Count
);

  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic             a_valid_q, a_valid_d;
  logic [WIDTH-1:0] b_data_q, b_data_d;
  logic             b_valid_q, b_valid_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

  logic a_room, b_room;
  logic a_fire, b_fire;
  logic in_fire_a, in_fire_b;

  // A slot can take a beat when it is empty or draining this cycle.
  assign a_room   = ~a_valid_q | A_Ready;
  assign b_room   = ~b_valid_q | B_Ready;
  assign In_Ready = In_Sel ? b_room : a_room;

  assign a_fire    = a_valid_q & A_Ready;
  assign b_fire    = b_valid_q & B_Ready;
  assign in_fire_a = In_Valid & ~In_Sel & a_room;
  assign in_fire_b = In_Valid &  In_Sel & b_room;

  // Next state of both holding registers: fill wins over drain (no bubble).
  always_comb begin
    a_data_d  = a_data_q;
    a_valid_d = a_valid_q;
    b_data_d  = b_data_q;
    b_valid_d = b_valid_q;
    if (in_fire_a) begin
      a_data_d  = In_Data;
      a_valid_d = 1'b1;
    end else if (a_fire) begin
      a_valid_d = 1'b0;
    end
    if (in_fire_b) begin
      b_data_d  = In_Data;
      b_valid_d = 1'b1;
    end else if (b_fire) begin
      b_valid_d = 1'b0;
    end
  end

  // Next state of the handshake counters: clear beats increment, wrap is natural.
  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (Clr) begin
      a_cnt_d = '0;
      b_cnt_d = '0;
    end else begin
      if (a_fire) a_cnt_d = a_cnt_q + CNT_W'(1);
      if (b_fire) b_cnt_d = b_cnt_q + CNT_W'(1);
    end
  end

  // Data path state register; reset discards any held beat.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_data_q  <= '0;
      a_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_valid_q <= 1'b0;
    end else begin
      a_data_q  <= a_data_d;
      a_valid_q <= a_valid_d;
      b_data_q  <= b_data_d;
      b_valid_q <= b_valid_d;
    end
  end

  // Counter state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign A_Data  = a_data_q;
  assign A_Valid = a_valid_q;
  assign B_Data  = b_data_q;
  assign B_Valid = b_valid_q;
  assign A_Count = a_cnt_q;
  assign B_Count = b_cnt_q;

endmodule

// File: tb/tb_stream_demux2.sv
// Testbench for stream_demux2: directed scenarios plus random traffic against a queue model.
module tb_stream_demux2;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CMOD  = 1 << CNT_W;

  logic             Clk;
  logic             Rst_n;
  logic [WIDTH-1:0] In_Data;
  logic             In_Sel;
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] A_Data;
  logic             A_Valid;
  logic             A_Ready;
  logic [WIDTH-1:0] B_Data;
  logic             B_Valid;
  logic             B_Ready;
  logic             Clr;
  logic [CNT_W-1:0] A_Count;
  logic [CNT_W-1:0] B_Count;

  stream_demux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .In_Data(In_Data), .In_Sel(In_Sel), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .A_Data(A_Data), .A_Valid(A_Valid), .A_Ready(A_Ready),
    .B_Data(B_Data), .B_Valid(B_Valid), .B_Ready(B_Ready),
    .Clr(Clr), .A_Count(A_Count), .B_Count(B_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each output is a FIFO of capacity one; counts are handshake tallies.
  int q_a[$];
  int q_b[$];
  int cnt_a = 0;
  int cnt_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_a_valid"}, 32'(A_Valid), 32'(q_a.size() != 0));
    check({tag, "_b_valid"}, 32'(B_Valid), 32'(q_b.size() != 0));
    if (q_a.size() != 0) check({tag, "_a_data"}, 32'(A_Data), 32'(q_a[0]));
    if (q_b.size() != 0) check({tag, "_b_data"}, 32'(B_Data), 32'(q_b[0]));
    check({tag, "_a_cnt"}, 32'(A_Count), 32'(cnt_a));
    check({tag, "_b_cnt"}, 32'(B_Count), 32'(cnt_b));
  endtask

  // One clock cycle: drive inputs, check In_Ready, advance model across the edge, check outputs.
  task automatic cycle(input string tag, input logic v, input logic s, input int d,
                       input logic ar, input logic br, input logic clr);
    bit exp_rdy, pop_a, pop_b, fire;
    In_Valid = v;
    In_Sel   = s;
    In_Data  = WIDTH'(d);
    A_Ready  = ar;
    B_Ready  = br;
    Clr      = clr;
    #1;
    exp_rdy = s ? (q_b.size() == 0 || br) : (q_a.size() == 0 || ar);
    check({tag, "_in_ready"}, 32'(In_Ready), 32'(exp_rdy));
    pop_a = (q_a.size() != 0) && ar;
    pop_b = (q_b.size() != 0) && br;
    fire  = v && exp_rdy;
    @(posedge Clk);
    #1;
    if (pop_a) void'(q_a.pop_front());
    if (pop_b) void'(q_b.pop_front());
    if (fire && !s) q_a.push_back(d % (1 << WIDTH));
    if (fire &&  s) q_b.push_back(d % (1 << WIDTH));
    if (clr) begin
      cnt_a = 0;
      cnt_b = 0;
    end else begin
      if (pop_a) cnt_a = (cnt_a + 1) % CMOD;
      if (pop_b) cnt_b = (cnt_b + 1) % CMOD;
    end
    check_outputs(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_valid"}, 32'(A_Valid), 32'd0);
    check({tag, "_b_valid"}, 32'(B_Valid), 32'd0);
    check({tag, "_a_data"},  32'(A_Data),  32'd0);
    check({tag, "_b_data"},  32'(B_Data),  32'd0);
    check({tag, "_a_cnt"},   32'(A_Count), 32'd0);
    check({tag, "_b_cnt"},   32'(B_Count), 32'd0);
  endtask

  initial begin
    Rst_n = 1'b0; In_Data = '0; In_Sel = 1'b0; In_Valid = 1'b0;
    A_Ready = 1'b1; B_Ready = 1'b1; Clr = 1'b0;

    // Reset then steer
    #3 check_all_zero("rst");
    @(posedge Clk); #1 check_all_zero("rst_edge");
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk); #1;
    cycle("steer0", 1'b1, 1'b0, 'h3, 1'b1, 1'b1, 1'b0);
    check("steer0_a_data_k", 32'(A_Data), 32'h3);
    cycle("steer1", 1'b1, 1'b1, 'h9, 1'b1, 1'b1, 1'b0);
    check("steer1_b_data_k", 32'(B_Data), 32'h9);
    cycle("steer2", 1'b0, 1'b0, 'h0, 1'b1, 1'b1, 1'b0);
    check("steer_a_cnt_k", 32'(A_Count), 32'd1);
    check("steer_b_cnt_k", 32'(B_Count), 32'd1);

    // Backpressure hold
    cycle("bp0", 1'b1, 1'b0, 'h5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("bp_stall", 1'b1, 1'b0, 'h6, 1'b0, 1'b1, 1'b0);
      check("bp_stall_a_data_k", 32'(A_Data), 32'h5);
    end
    cycle("bp_go", 1'b1, 1'b0, 'h6, 1'b1, 1'b1, 1'b0);
    check("bp_go_a_data_k", 32'(A_Data), 32'h6);
    cycle("bp_drain", 1'b0, 1'b0, 'h0, 1'b1, 1'b1, 1'b0);
    check("bp_a_cnt_k", 32'(A_Count), 32'd3);

    // Independence: A stalled and full, B still accepts
    cycle("ind0", 1'b1, 1'b0, 'h5, 1'b0, 1'b1, 1'b0);
    cycle("ind1", 1'b1, 1'b1, 'hC, 1'b0, 1'b1, 1'b0);
    check("ind_b_data_k", 32'(B_Data), 32'hC);
    check("ind_a_hold_k", 32'(A_Data), 32'h5);

    // Simultaneous drain and fill on A
    cycle("df", 1'b1, 1'b0, 'h7, 1'b1, 1'b1, 1'b0);
    check("df_a_valid_k", 32'(A_Valid), 32'd1);
    check("df_a_data_k", 32'(A_Data), 32'h7);
    cycle("df_drain", 1'b0, 1'b0, 'h0, 1'b1, 1'b1, 1'b0);

    // Counter wrap and clear
    cycle("clr0", 1'b0, 1'b0, 'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 256; i++)
      cycle("wrap", 1'b1, 1'b0, int'($urandom_range(15)), 1'b1, 1'b1, 1'b0);
    cycle("wrap_end", 1'b0, 1'b0, 'h0, 1'b1, 1'b1, 1'b0);
    check("wrap_a_cnt_k", 32'(A_Count), 32'd0);
    cycle("clr_b0", 1'b1, 1'b1, 'hA, 1'b1, 1'b1, 1'b0);
    cycle("clr_b1", 1'b0, 1'b0, 'h0, 1'b1, 1'b1, 1'b1);
    check("clr_b_cnt_k", 32'(B_Count), 32'd0);

    // Async reset mid-stream with both outputs full
    cycle("ar0", 1'b1, 1'b0, 'hE, 1'b0, 1'b0, 1'b0);
    cycle("ar1", 1'b1, 1'b1, 'hD, 1'b0, 1'b0, 1'b0);
    In_Valid = 1'b0;
    #2 Rst_n = 1'b0;
    #1 check_all_zero("ar_async");
    q_a.delete(); q_b.delete(); cnt_a = 0; cnt_b = 0;
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk); #1;
    cycle("ar_post0", 1'b0, 1'b0, 'h0, 1'b0, 1'b0, 1'b0);
    cycle("ar_post1", 1'b0, 1'b1, 'h0, 1'b1, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cycle("rnd", 1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(15)),
            1'($urandom_range(3) != 0), 1'($urandom_range(3) == 0),
            1'($urandom_range(63) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
